// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer.
// Holds the funct3 size encodings, fault cause codes, the controller state
// encoding and small decode helpers used when an access is accepted.
package lsu_pkg;

    // funct3 size encodings as presented by decode
    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    // Fault cause codes reported alongside done_o
    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // True for the three funct3 codes that have no load/store meaning
    function automatic logic size_illegal(input logic [2:0] sz);
        logic ill;
        case (sz)
            SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: ill = 1'b0;
            default:                        ill = 1'b1;
        endcase
        return ill;
    endfunction

    // True when the byte offset does not suit the access width
    function automatic logic size_misaligned(input logic [2:0] sz, input logic [1:0] off);
        logic mis;
        case (sz)
            SZ_H, SZ_HU: mis = off[0];
            SZ_W:        mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store sequencer (purely combinational).
// Ports:
//   i_st_size/i_st_off/i_wdata -> o_be, o_wdata : lanes for the access being issued
//   i_ld_size/i_ld_off/i_rdata -> o_ld_data     : extract + extend the returned word
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_ld_size,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte enables and lane-replicated store data for the access being issued
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_st_size)
            SZ_B, SZ_BU: begin
                o_be    = 4'b0001 << i_st_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_H, SZ_HU: begin
                o_be    = 4'b0011 << i_st_off;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    // Select the addressed byte/half and extend it to 32 bits
    always_comb begin
        w_byte    = 8'h00;
        w_half    = 16'h0000;
        o_ld_data = i_rdata;
        case (i_ld_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        if (i_ld_off[1]) begin
            w_half = i_rdata[31:16];
        end else begin
            w_half = i_rdata[15:0];
        end
        case (i_ld_size)
            SZ_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            SZ_BU:   o_ld_data = {24'h000000, w_byte};
            SZ_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            SZ_HU:   o_ld_data = {16'h0000, w_half};
            default: o_ld_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between decode controls and a req/ack data memory.
// Checks size and alignment, issues one registered memory request, stalls the
// pipeline until the access completes and returns extended load data.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mem_read_i, mem_write_i          operation requests (held while stalled)
//   data_size_i, addr_i, wdata_i     funct3 size, byte address, store data
//   stall_o, done_o                  pipeline freeze, one-cycle completion pulse
//   rdata_o, fault_o, fault_cause_o  load result and fault report
//   m_req_o..m_wdata_o, m_ack_i, m_rdata_i  memory-side handshake
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  data_size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [31:0] m_addr_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_wdata_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_rdata_i
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_e r_state;
    lsu_state_e w_next;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_size;
    logic [1:0]    r_off;
    logic          r_done;
    logic          r_fault;
    logic [1:0]    r_cause;
    logic [31:0]   r_rdata;
    logic          r_m_req;
    logic          r_m_we;
    logic [31:0]   r_m_addr;
    logic [3:0]    r_m_be;
    logic [31:0]   r_m_wdata;

    logic        w_op;
    logic        w_stall;
    logic        w_accept;
    logic        w_fault_set;
    logic [1:0]  w_cause;
    logic        w_ack_take;
    logic        w_cnt_inc;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_data;

    assign w_op = mem_read_i | mem_write_i;

    lsu_align u_align (
        .i_st_size (data_size_i),
        .i_st_off  (addr_i[1:0]),
        .i_wdata   (wdata_i),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .i_ld_size (r_size),
        .i_ld_off  (r_off),
        .i_rdata   (m_rdata_i),
        .o_ld_data (w_ld_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode, stall generation and per-cycle actions
    always_comb begin
        w_next      = r_state;
        w_stall     = 1'b0;
        w_accept    = 1'b0;
        w_fault_set = 1'b0;
        w_cause     = CAUSE_NONE;
        w_ack_take  = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_op) begin
                    w_stall = 1'b1;
                    if ((mem_read_i & mem_write_i) | size_illegal(data_size_i)) begin
                        w_next      = ST_DONE;
                        w_fault_set = 1'b1;
                        w_cause     = CAUSE_ILLEGAL;
                    end else if (size_misaligned(data_size_i, addr_i[1:0])) begin
                        w_next      = ST_DONE;
                        w_fault_set = 1'b1;
                        w_cause     = CAUSE_MISALIGN;
                    end else begin
                        w_next   = ST_REQ;
                        w_accept = 1'b1;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                w_stall = 1'b1;
                if (m_ack_i) begin
                    w_next     = ST_DONE;
                    w_ack_take = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_next      = ST_DONE;
                    w_fault_set = 1'b1;
                    w_cause     = CAUSE_TIMEOUT;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Datapath, memory-side and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_size    <= 3'd0;
            r_off     <= 2'd0;
            r_done    <= 1'b0;
            r_fault   <= 1'b0;
            r_cause   <= CAUSE_NONE;
            r_rdata   <= 32'h0000_0000;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= 32'h0000_0000;
            r_m_be    <= 4'b0000;
            r_m_wdata <= 32'h0000_0000;
        end else begin
            r_done <= (w_next == ST_DONE);
            if (w_accept) begin
                r_cnt     <= '0;
                r_size    <= data_size_i;
                r_off     <= addr_i[1:0];
                r_m_req   <= 1'b1;
                r_m_we    <= mem_write_i;
                r_m_addr  <= {addr_i[31:2], 2'b00};
                r_m_be    <= w_be;
                r_m_wdata <= w_wdata;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= r_cnt;
            end
            // Request drops on the edge that leaves REQ, ack or timeout
            if (w_ack_take | (w_fault_set & (r_state == ST_REQ))) begin
                r_m_req <= 1'b0;
            end else begin
                r_m_req <= r_m_req | w_accept;
            end
            if (w_ack_take & ~r_m_we) begin
                r_rdata <= w_ld_data;
            end else begin
                r_rdata <= r_rdata;
            end
            if (w_fault_set) begin
                r_fault <= 1'b1;
                r_cause <= w_cause;
            end else if (r_state == ST_DONE) begin
                r_fault <= 1'b0;
                r_cause <= CAUSE_NONE;
            end else begin
                r_fault <= r_fault;
                r_cause <= r_cause;
            end
        end
    end

    // Stall is held low while reset is asserted so outputs read as idle
    assign stall_o       = w_stall & ~rst;
    assign done_o        = r_done;
    assign rdata_o       = r_rdata;
    assign fault_o       = r_fault;
    assign fault_cause_o = r_cause;
    assign m_req_o       = r_m_req;
    assign m_we_o        = r_m_we;
    assign m_addr_o      = r_m_addr;
    assign m_be_o        = r_m_be;
    assign m_wdata_o     = r_m_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a vector table of single accesses plus
// hand-written sequences for late acks and reset during an access.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  data_size_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, done_o, fault_o;
    logic [31:0] rdata_o;
    logic [1:0]  fault_cause_o;
    logic        m_req_o, m_we_o;
    logic [31:0] m_addr_o, m_wdata_o;
    logic [3:0]  m_be_o;
    logic        m_ack_i;
    logic [31:0] m_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .data_size_i(data_size_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
        .fault_o(fault_o), .fault_cause_o(fault_cause_o),
        .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o),
        .m_be_o(m_be_o), .m_wdata_o(m_wdata_o),
        .m_ack_i(m_ack_i), .m_rdata_i(m_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mword;
        int          delay;
        int          exp_nreq;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_fault;
        logic [1:0]  exp_cause;
        logic [31:0] exp_rdata;
        int          exp_cycles;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        data_size_i = 3'd0;
        addr_i      = 32'h0;
        wdata_i     = 32'h0;
        m_ack_i     = 1'b0;
        m_rdata_i   = 32'h0;
    endtask

    // Apply one access at a negedge and follow it to its done_o pulse
    task automatic run_vec(input vec_t v);
        int  c;
        int  nreq;
        bit  seen;
        mem_read_i  = v.rd;
        mem_write_i = v.wr;
        data_size_i = v.size;
        addr_i      = v.addr;
        wdata_i     = v.wdata;
        m_ack_i     = 1'b0;
        #1;
        chk({v.name, ".stall_accept"}, {31'b0, stall_o}, 32'd1);
        c    = 1;
        nreq = 0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            c++;
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            if (m_req_o) begin
                if (nreq == 0) begin
                    chk({v.name, ".be"},    {28'b0, m_be_o}, {28'b0, v.exp_be});
                    chk({v.name, ".wdata"}, m_wdata_o, v.exp_wdata);
                    chk({v.name, ".we"},    {31'b0, m_we_o}, {31'b0, v.wr});
                    chk({v.name, ".maddr"}, m_addr_o, {v.addr[31:2], 2'b00});
                end
                m_ack_i   = (nreq == v.delay);
                m_rdata_i = (nreq == v.delay) ? v.mword : 32'hA5A5_A5A5;
                nreq++;
            end else begin
                m_ack_i = 1'b0;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.done_wait: no done_o within 20 cycles", v.name);
        end
        chk({v.name, ".cycles"}, c, v.exp_cycles);
        chk({v.name, ".nreq"},   nreq, v.exp_nreq);
        chk({v.name, ".fault"},  {31'b0, fault_o}, {31'b0, v.exp_fault});
        chk({v.name, ".cause"},  {30'b0, fault_cause_o}, {30'b0, v.exp_cause});
        chk({v.name, ".rdata"},  rdata_o, v.exp_rdata);
        chk({v.name, ".stall_done"}, {31'b0, stall_o}, 32'd0);
        idle_inputs();
        @(negedge clk);
        chk({v.name, ".done_pulse"}, {31'b0, done_o}, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        // name rd wr size addr wdata mword delay nreq be wdata fault cause rdata cycles
        vecs.push_back('{"LB",   1'b1, 1'b0, 3'd0, 32'h1003, 32'h0, 32'h80FF_1234, 2, 3, 4'b1000, 32'h0, 1'b0, 2'd0, 32'hFFFF_FF80, 5});
        vecs.push_back('{"SH",   1'b0, 1'b1, 3'd1, 32'h2002, 32'h0000_BEEF, 32'h0, 0, 1, 4'b1100, 32'hBEEF_BEEF, 1'b0, 2'd0, 32'hFFFF_FF80, 3});
        vecs.push_back('{"LHU",  1'b1, 1'b0, 3'd5, 32'h2002, 32'h0, 32'h8001_0000, 0, 1, 4'b1100, 32'h0, 1'b0, 2'd0, 32'h0000_8001, 3});
        vecs.push_back('{"LWmis",1'b1, 1'b0, 3'd2, 32'h1001, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 1'b1, 2'd1, 32'h0000_8001, 2});
        vecs.push_back('{"ILL3", 1'b1, 1'b0, 3'd3, 32'h1000, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 1'b1, 2'd2, 32'h0000_8001, 2});
        vecs.push_back('{"BOTH", 1'b1, 1'b1, 3'd2, 32'h1000, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 1'b1, 2'd2, 32'h0000_8001, 2});
        vecs.push_back('{"LHmis",1'b1, 1'b0, 3'd1, 32'h3001, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 1'b1, 2'd1, 32'h0000_8001, 2});
        vecs.push_back('{"LW",   1'b1, 1'b0, 3'd2, 32'h4000, 32'h0, 32'hDEAD_BEEF, 1, 2, 4'b1111, 32'h0, 1'b0, 2'd0, 32'hDEAD_BEEF, 4});
        vecs.push_back('{"LBU",  1'b1, 1'b0, 3'd4, 32'h4001, 32'h0, 32'h1234_A5CC, 0, 1, 4'b0010, 32'h0, 1'b0, 2'd0, 32'h0000_00A5, 3});
        vecs.push_back('{"LH",   1'b1, 1'b0, 3'd1, 32'h4002, 32'h0, 32'h9ABC_0000, 0, 1, 4'b1100, 32'h0, 1'b0, 2'd0, 32'hFFFF_9ABC, 3});
        vecs.push_back('{"SB",   1'b0, 1'b1, 3'd0, 32'h5001, 32'h1122_3344, 32'h0, 0, 1, 4'b0010, 32'h4444_4444, 1'b0, 2'd0, 32'hFFFF_9ABC, 3});
        vecs.push_back('{"SW",   1'b0, 1'b1, 3'd2, 32'h6000, 32'hCAFE_F00D, 32'h0, 1, 2, 4'b1111, 32'hCAFE_F00D, 1'b0, 2'd0, 32'hFFFF_9ABC, 4});
        vecs.push_back('{"LWto", 1'b1, 1'b0, 3'd2, 32'h7000, 32'h0, 32'h0, 99, 4, 4'b1111, 32'h0, 1'b1, 2'd3, 32'hFFFF_9ABC, 6});

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.stall", {31'b0, stall_o}, 32'd0);
        chk("rst.done",  {31'b0, done_o}, 32'd0);
        chk("rst.rdata", rdata_o, 32'd0);
        chk("rst.fault", {29'b0, fault_o, fault_cause_o}, 32'd0);
        chk("rst.mreq",  {31'b0, m_req_o}, 32'd0);
        chk("rst.mside", {m_be_o, 27'b0, m_we_o} ^ m_addr_o ^ m_wdata_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // Late ack after the timeout must be ignored
        m_ack_i   = 1'b1;
        m_rdata_i = 32'h1111_1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_ack.done", {31'b0, done_o}, 32'd0);
            chk("late_ack.mreq", {31'b0, m_req_o}, 32'd0);
        end
        chk("late_ack.rdata", rdata_o, 32'hFFFF_9ABC);
        idle_inputs();
        @(negedge clk);

        // Reset in the 2nd REQ cycle abandons the access
        mem_read_i  = 1'b1;
        data_size_i = 3'd2;
        addr_i      = 32'h0000_8000;
        @(negedge clk);
        chk("rstmid.req1", {31'b0, m_req_o}, 32'd1);
        @(negedge clk);
        chk("rstmid.req2", {31'b0, m_req_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid.mreq",  {31'b0, m_req_o}, 32'd0);
        chk("rstmid.stall", {31'b0, stall_o}, 32'd0);
        chk("rstmid.done",  {31'b0, done_o}, 32'd0);
        idle_inputs();
        rst       = 1'b0;
        m_ack_i   = 1'b1;
        m_rdata_i = 32'h2222_2222;
        @(negedge clk);
        chk("rstmid.lateack", {31'b0, done_o}, 32'd0);
        m_ack_i = 1'b0;
        @(negedge clk);
        run_vec('{"LWpost", 1'b1, 1'b0, 3'd2, 32'h8004, 32'h0, 32'h0102_0304, 0, 1, 4'b1111, 32'h0, 1'b0, 2'd0, 32'h0102_0304, 3});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
